// File: rtl/isqrt_sched_pkg.sv
// isqrt_sched_pkg: shared types and default sizing for the isqrt round-robin scheduler
package isqrt_sched_pkg;
  typedef logic [31:0] arg_t;
  typedef logic [15:0] res_t;
  localparam int DEF_N_REQ = 4;
  localparam int DEF_PIPE_DEPTH = 4;
endpackage

// File: rtl/isqrt_rr_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin grant, first requester at or above ptr wins (wrapping)
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);
  // scan from the farthest offset down so the nearest match overwrites
  always_comb begin
    gnt = '0;
    gnt_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        gnt = '0;
        gnt[(int'(ptr) + k) % N] = 1'b1;
        gnt_idx = IW'((int'(ptr) + k) % N);
      end
    end
  end
endmodule

// File: rtl/isqrt_rr_sched.sv
// isqrt_rr_sched: round-robin scheduler sharing one external pipelined isqrt among N_REQ requesters
// Define ISQRT_RR_SCHED_ERR_CHECK_EN to build the sticky tag/valid mismatch checker driving err.
module isqrt_rr_sched
  import isqrt_sched_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int PIPE_DEPTH = DEF_PIPE_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_vld,
  input  arg_t [N_REQ-1:0]      req_x,
  output logic [N_REQ-1:0]      req_rdy,
  output logic                  sq_x_vld,
  output arg_t                  sq_x,
  input  logic                  sq_y_vld,
  input  res_t                  sq_y,
  output logic [N_REQ-1:0]      rsp_vld,
  output res_t                  rsp_y,
  output logic                  err
);
  localparam int IW = $clog2(N_REQ);
  logic [IW-1:0] ptr, gnt_idx, x_id;
  logic [IW-1:0] tid [PIPE_DEPTH];
  logic [PIPE_DEPTH-1:0] tv;
  logic grant, out_vld;
  rr_arbiter #(.N(N_REQ)) u_arb (.req(req_vld), .ptr, .gnt(req_rdy), .gnt_idx);
  assign grant = |req_vld;
  assign out_vld = tv[PIPE_DEPTH-1] & sq_y_vld;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ptr <= '0;
      sq_x_vld <= 1'b0;
      tv <= '0;
      rsp_vld <= '0;
    end else begin
      if (grant) ptr <= (int'(gnt_idx) == N_REQ - 1) ? '0 : gnt_idx + 1'b1;
      sq_x_vld <= grant;
      tv <= (tv << 1) | PIPE_DEPTH'(sq_x_vld);
      rsp_vld <= out_vld ? N_REQ'(1) << tid[PIPE_DEPTH-1] : '0;
    end
  // datapath and tag ids stay unreset; only the valids above qualify them
  always_ff @(posedge clk) begin
    if (grant) begin
      sq_x <= req_x[gnt_idx];
      x_id <= gnt_idx;
    end
    if (out_vld) rsp_y <= sq_y;
    tid[0] <= x_id;
    for (int i = 1; i < PIPE_DEPTH; i++) tid[i] <= tid[i-1];
  end
`ifdef ISQRT_RR_SCHED_ERR_CHECK_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) err <= 1'b0;
    else if (sq_y_vld != tv[PIPE_DEPTH-1]) err <= 1'b1;
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_isqrt_rr_sched.sv
// tb_isqrt_rr_sched: scoreboard bench for isqrt_rr_sched with a behavioural pipelined isqrt
module tb_isqrt_rr_sched;
  localparam int N = 4, PD = 4;
  logic clk = 1'b0, rst = 1'b1, spur = 1'b0;
  logic [N-1:0] req_vld = '0;
  logic [N-1:0] req_rdy, rsp_vld;
  logic [N-1:0][31:0] req_x = '0;
  logic sq_x_vld, sq_y_vld, err;
  logic [31:0] sq_x;
  logic [15:0] sq_y, rsp_y;
  logic [PD-1:0] mv;
  logic [15:0] my [PD];
  int checks = 0, failures = 0, cyc = 0;
  typedef struct {int id; logic [15:0] y; int t;} sb_t;
  sb_t sb[$];

  isqrt_rr_sched #(.N_REQ(N), .PIPE_DEPTH(PD)) dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_x(req_x), .req_rdy(req_rdy),
    .sq_x_vld(sq_x_vld), .sq_x(sq_x), .sq_y_vld(sq_y_vld), .sq_y(sq_y),
    .rsp_vld(rsp_vld), .rsp_y(rsp_y), .err(err));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] isqrt(input logic [31:0] x);
    logic [15:0] r, t;
    r = '0;
    for (int b = 15; b >= 0; b--) begin
      t = r | (16'd1 << b);
      if (longint'(t) * longint'(t) <= longint'(x)) r = t;
    end
    return r;
  endfunction

  always @(posedge clk or posedge rst)
    if (rst) mv <= '0;
    else begin
      mv <= {mv[PD-2:0], sq_x_vld};
      my[0] <= isqrt(sq_x);
      for (int i = 1; i < PD; i++) my[i] <= my[i-1];
    end
  assign sq_y_vld = mv[PD-1] | spur;
  assign sq_y = my[PD-1];

  task automatic mid();
    @(negedge clk);
    if (rst) sb.delete();
    else begin
      for (int i = 0; i < N; i++)
        if (req_vld[i] && req_rdy[i]) sb.push_back(sb_t'{i, isqrt(req_x[i]), cyc + PD + 2});
      if (|rsp_vld) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected rsp_vld=%b rsp_y=%0d required no response", rsp_vld, rsp_y);
        end else begin
          sb_t e;
          e = sb.pop_front();
          if (rsp_vld !== (4'b1 << e.id) || rsp_y !== e.y || cyc !== e.t) begin
            failures++;
            $display("FAIL sb_rsp got vld=%b y=%0d cyc=%0d required vld=%b y=%0d cyc=%0d",
                     rsp_vld, rsp_y, cyc, 4'b1 << e.id, e.y, e.t);
          end
        end
      end
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    mid();
    nxt();
  endtask

  task automatic test_reset();
    mid();
    checks++;
    if (req_rdy !== 4'b0 || sq_x_vld !== 1'b0 || rsp_vld !== 4'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got rdy=%b xv=%b rv=%b err=%b required 0000 0 0000 0",
               req_rdy, sq_x_vld, rsp_vld, err);
    end
    nxt();
    req_vld = 4'hF;
    mid();
    checks++;
    if (req_rdy !== 4'b0001) begin
      failures++;
      $display("FAIL reset_ptr got rdy=%b required 0001", req_rdy);
    end
    nxt();
    rst = 1'b0;
    req_vld = '0;
  endtask

  task automatic test_single();
    int t0;
    bit got;
    got = 0;
    req_vld = 4'b0010;
    req_x[1] = 32'd81;
    mid();
    checks++;
    if (req_rdy !== 4'b0010) begin
      failures++;
      $display("FAIL single_grant got rdy=%b required 0010", req_rdy);
    end
    t0 = cyc;
    nxt();
    req_vld = '0;
    for (int k = 0; k < 20; k++) begin
      mid();
      if (|rsp_vld && !got) begin
        got = 1;
        checks++;
        if (rsp_vld !== 4'b0010 || rsp_y !== 16'd9 || cyc - t0 !== 6) begin
          failures++;
          $display("FAIL single_rsp got vld=%b y=%0d lat=%0d required 0010 9 6", rsp_vld, rsp_y, cyc - t0);
        end
      end
      nxt();
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL single_timeout got no rsp_vld required one response");
    end
  endtask

  task automatic test_back_to_back();
    int seen;
    seen = 0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 30; k++) begin
      req_vld = (k < 8) ? 4'hF : 4'h0;
      for (int j = 0; j < N; j++) req_x[j] = $urandom;
      mid();
      if (k < 8) begin
        checks++;
        if (req_rdy !== (4'b1 << (k % 4))) begin
          failures++;
          $display("FAIL b2b_grant[%0d] got rdy=%b required %b", k, req_rdy, 4'b1 << (k % 4));
        end
      end
      if ((|rsp_vld || seen > 0) && seen < 8) begin
        checks++;
        if (rsp_vld !== (4'b1 << (seen % 4))) begin
          failures++;
          $display("FAIL b2b_rsp[%0d] got vld=%b required %b", seen, rsp_vld, 4'b1 << (seen % 4));
        end
        seen++;
      end
      nxt();
    end
    checks++;
    if (seen != 8) begin
      failures++;
      $display("FAIL b2b_count got %0d responses required 8", seen);
    end
  endtask

  task automatic test_rr_ptr();
    req_vld = 4'b0001;
    mid();
    checks++;
    if (req_rdy !== 4'b0001) begin
      failures++;
      $display("FAIL rr_setup got rdy=%b required 0001", req_rdy);
    end
    nxt();
    req_vld = 4'b0101;
    mid();
    checks++;
    if (req_rdy !== 4'b0100) begin
      failures++;
      $display("FAIL rr_first got rdy=%b required 0100", req_rdy);
    end
    nxt();
    mid();
    checks++;
    if (req_rdy !== 4'b0001) begin
      failures++;
      $display("FAIL rr_second got rdy=%b required 0001", req_rdy);
    end
    nxt();
    req_vld = '0;
    repeat (10) tick();
  endtask

  task automatic test_reset_inflight();
    req_vld = 4'hF;
    repeat (3) tick();
    req_vld = '0;
    repeat (2) tick();
    checks++;
    if (sb.size() != 3) begin
      failures++;
      $display("FAIL rst_inflight_pending got %0d in flight required 3", sb.size());
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      mid();
      checks++;
      if (rsp_vld !== 4'b0 || err !== 1'b0) begin
        failures++;
        $display("FAIL rst_flush[%0d] got rv=%b err=%b required 0000 0", k, rsp_vld, err);
      end
      nxt();
    end
  endtask

  task automatic test_max();
    bit got;
    got = 0;
    req_vld = 4'b1000;
    req_x[3] = 32'hFFFF_FFFF;
    tick();
    req_vld = '0;
    req_x[3] = 32'h1234_5678;
    for (int k = 0; k < 20; k++) begin
      mid();
      if (|rsp_vld && !got) begin
        got = 1;
        checks++;
        if (rsp_vld !== 4'b1000 || rsp_y !== 16'hFFFF) begin
          failures++;
          $display("FAIL max_rsp got vld=%b y=%0d required 1000 65535", rsp_vld, rsp_y);
        end
      end
      nxt();
    end
    mid();
    checks++;
    if (!got || sq_x !== 32'hFFFF_FFFF || sq_x_vld !== 1'b0) begin
      failures++;
      $display("FAIL max_hold got seen=%0d sq_x=%h xv=%b required 1 ffffffff 0", got, sq_x, sq_x_vld);
    end
    nxt();
  endtask

  task automatic test_spurious();
    spur = 1'b1;
    tick();
    spur = 1'b0;
    mid();
    checks++;
    if (rsp_vld !== 4'b0) begin
      failures++;
      $display("FAIL spur_rsp got vld=%b required 0000", rsp_vld);
    end
`ifdef ISQRT_RR_SCHED_ERR_CHECK_EN
    checks++;
    if (err !== 1'b1) begin
      failures++;
      $display("FAIL spur_err_rise got err=%b required 1", err);
    end
    nxt();
    repeat (4) tick();
    mid();
    checks++;
    if (err !== 1'b1) begin
      failures++;
      $display("FAIL spur_err_sticky got err=%b required 1", err);
    end
    nxt();
    rst = 1'b1;
    mid();
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL spur_err_clear got err=%b required 0", err);
    end
    nxt();
    rst = 1'b0;
`else
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL spur_err_tied got err=%b required 0", err);
    end
    nxt();
`endif
  endtask

  initial begin
    nxt();
    test_reset();
    test_single();
    test_back_to_back();
    test_rr_ptr();
    test_reset_inflight();
    test_max();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_drain got %0d outstanding required 0", sb.size());
    end
    test_spurious();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got no completion required finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/isqrt_rr_sched.md
ISQRT_RR_SCHED -- requirements
Module: isqrt_rr_sched

Interface
- Parameters
REQ-001 The block SHALL have parameter N_REQ, default 4, giving the number of requesters sharing one pipelined isqrt (legal 2..8).
REQ-002 The block SHALL have parameter PIPE_DEPTH, default 4, giving the isqrt x_vld-to-y_vld latency in cycles (legal 1..16).
- Ports
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port req_vld, input, N_REQ bits: per-requester argument valid.
REQ-006 The block SHALL have port req_x, input, N_REQ x 32 bits: per-requester argument.
REQ-007 The block SHALL have port req_rdy, output, N_REQ bits: one-hot-or-zero grant; a transfer occurs when req_vld[i] and req_rdy[i] are both high.
REQ-008 The block SHALL have port sq_x_vld, output, 1 bit: drives isqrt x_vld.
REQ-009 The block SHALL have port sq_x, output, 32 bits: drives isqrt x.
REQ-010 The block SHALL have port sq_y_vld, input, 1 bit: from isqrt y_vld.
REQ-011 The block SHALL have port sq_y, input, 16 bits: from isqrt y.
REQ-012 The block SHALL have port rsp_vld, output, N_REQ bits: per-requester result strobe, at most one bit high per cycle.
REQ-013 The block SHALL have port rsp_y, output, 16 bits: the result, valid while any rsp_vld bit is high.
REQ-014 The block SHALL have port err, output, 1 bit: sticky tag/valid mismatch flag.

Function
REQ-015 Arbitration SHALL be round-robin: a pointer ptr selects the first i with req_vld[i] set, searching from ptr upward and wrapping modulo N_REQ.
REQ-016 req_rdy SHALL be combinational from req_vld and ptr, SHALL be all-zero when req_vld is zero, and SHALL NOT depend on req_rdy.
REQ-017 On a grant to index g, ptr SHALL become (g+1) mod N_REQ on the next edge; with no grant, ptr SHALL hold.
REQ-018 The block SHALL accept at most one argument per cycle and SHALL sustain one grant every cycle (no bubbles) while any req_vld bit is high.
REQ-019 sq_x_vld SHALL be registered: it SHALL be high in cycle T+1 exactly when a transfer occurs in cycle T.
REQ-020 sq_x SHALL load req_x[g] only on a grant and SHALL otherwise hold its value, to save dynamic power.
REQ-021 A tag shift pipe of PIPE_DEPTH entries {valid, id} SHALL follow sq_x_vld, so that the tag of the cycle-T grant reaches the output at cycle T+1+PIPE_DEPTH.
REQ-022 At cycle T+2+PIPE_DEPTH, rsp_vld[id] SHALL be high (registered) and rsp_y SHALL equal the registered sq_y; total latency from transfer to rsp_vld SHALL be PIPE_DEPTH+2.
REQ-023 rsp_y SHALL load only when sq_y_vld is high and tag valid is high; otherwise it SHALL hold.
REQ-024 Grants SHALL remain in acceptance order; responses to one requester SHALL NOT be reordered.

Reset
REQ-025 While rst is high, ptr SHALL be 0, sq_x_vld SHALL be 0, all tag valids SHALL be 0, rsp_vld SHALL be 0, and err SHALL be 0.
REQ-026 While rst is high, sq_x and rsp_y SHALL NOT be reset (datapath registers).
REQ-027 Asserting rst mid-operation SHALL discard all in-flight tags; any sq_y_vld seen after reset with no tag valid SHALL produce no rsp_vld.

Configuration
REQ-028 Macro ISQRT_RR_SCHED_ERR_CHECK_EN SHALL enable the mismatch checker.
REQ-029 With ISQRT_RR_SCHED_ERR_CHECK_EN defined, err SHALL set when sq_y_vld differs from the output tag valid, and SHALL clear only on rst.
REQ-030 Without ISQRT_RR_SCHED_ERR_CHECK_EN, err SHALL be tied to 0 and no checker logic SHALL be built.

Structure
REQ-031 The shared package isqrt_sched_pkg SHALL hold the arg_t (32-bit) and res_t (16-bit) typedefs and the default N_REQ and PIPE_DEPTH constants.
REQ-032 The round-robin grant logic SHALL be a sub-module named rr_arbiter (inputs req and ptr; outputs one-hot gnt and gnt_idx).
REQ-033 The isqrt itself SHALL NOT be instantiated inside the block; the bench/top SHALL connect it.

Verification
REQ-034 The bench SHALL cover: single requester 1 with req_x=81 for one cycle, PIPE_DEPTH=4 -> rsp_vld=4'b0010 and rsp_y=9 exactly 6 cycles after the transfer.
REQ-035 The bench SHALL cover: all four req_vld held high for 8 cycles from reset -> grants 0,1,2,3,0,1,2,3 and rsp_vld following the same order with no bubbles.
REQ-036 The bench SHALL cover: requesters 0 and 2 high, ptr=1 -> requester 2 is granted first, then 0.
REQ-037 The bench SHALL cover: rst pulse 2 cycles after three grants -> no rsp_vld after reset, and err stays 0.
REQ-038 The bench SHALL cover: with ISQRT_RR_SCHED_ERR_CHECK_EN, force a spurious sq_y_vld -> err rises next cycle and stays high until rst.
REQ-039 The bench SHALL cover: req_x=0xFFFFFFFF -> rsp_y=65535, and sq_x holds its value through idle cycles.
